dcache_mem_stage: RTL and testbench
===================================

// Module: dcache_mem_stage
// PURPOSE
//  Parametrised memory-stage data cache for the superscalar core: direct-mapped, write-through, no-write-allocate.
//  Sits between the M-stage datapath and a word-wide backing-memory req/ack port.
//  Supports RISC-V byte/half/word loads and stores (signed/unsigned) with multi-cycle line refill.
//  CacheStall freezes the pipeline during misses and stores.
// PARAMETERS
//  NUM_SETS        64  number of lines; power of 2, >=2
//  WORDS_PER_LINE  4   32-bit words per line; power of 2, >=1
//  ADDR_WIDTH      32  byte-address width
// PORTS
//  clk                 in   1   clock, all state on rising edge
//  rst                 in   1   reset; one clock; reset is synchronous and active-low (rst==0 resets)
//  AddressingControlM  in   3   funct3: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
//  MemReadM            in   1   load request this cycle
//  MemWriteM           in   1   store request this cycle
//  ALUResultM          in   ADDR_WIDTH  byte address
//  WriteDataM          in   32  store data, right-aligned
//  ReadDataM           out  32  load result, extended per funct3
//  CacheStall          out  1   hold M stage and upstream
//  mem_req             out  1   backing-memory request valid
//  mem_we              out  1   1=write beat, 0=read beat
//  mem_addr            out  ADDR_WIDTH  word-aligned address ([1:0]=0)
//  mem_wdata           out  32  lane-aligned write data
//  mem_wstrb           out  4   byte enables for the write
//  mem_rdata           in   32  read data, valid with mem_ack
//  mem_ack             in   1   beat complete; one beat per ack
// BEHAVIOUR
//  Address split: offset [1:0], word index log2(WPL), set index log2(NUM_SETS), tag = remaining upper bits.
//  Alignment: LW/SW ignore A[1:0]; LH/SH ignore A[0]. No misalignment trap.
//  Unlisted funct3 (011,110,111) behaves as LW/SW.
//  FSM states IDLE, FILL, WRITE. While reset is asserted:
//   - all valid bits cleared; FSM=IDLE; mem_req=0; store_done=0.
//  IDLE, load hit:
//   - ReadDataM driven combinationally in the same cycle; CacheStall=0; zero added latency.
//  IDLE, load miss:
//   - CacheStall=1 combinationally; next state FILL.
//  FILL:
//   - Issues WORDS_PER_LINE read beats from the line base, in ascending order, one outstanding.
//   - mem_req held high until mem_ack; each ack writes its word into data RAM.
//   - On the last ack: tag written, valid set, next state IDLE.
//   - Returning to IDLE re-evaluates as a hit, so a miss costs >= WPL+1 cycles.
//  IDLE, store (MemWriteM=1) with store_done=0:
//   - CacheStall=1; next state WRITE.
//  WRITE:
//   - mem_req=1, mem_we=1, mem_addr = word address.
//   - mem_wdata/mem_wstrb lane-shifted: SB strobe 1<<A[1:0]; SH strobe 0011 or 1100 by A[1]; SW 1111.
//   - CacheStall=1 for the whole state.
//   - On ack: if the line hits, the cached word is byte-merged under the strobe (miss: no allocate).
//   - On ack: store_done=1, next state IDLE.
//  IDLE, store with store_done=1: CacheStall=0 and the store retires.
//  store_done clears on any cycle with CacheStall=0.
//  MemReadM and MemWriteM both high: handled as a store.
//  Neither asserted: CacheStall=0, no memory traffic, ReadDataM don't-care (drive 0).
//  Load extension: LB/LH sign-extend; LBU/LHU zero-extend; byte lane taken from A[1:0].
//  Reset mid-FILL/WRITE: request abandoned, line left invalid; any late mem_ack while in IDLE is ignored.
//  mem_ack outside FILL/WRITE: ignored. Inputs are held stable by the pipeline while CacheStall=1.
// TESTING
//  1) Reset, LW 0x100, memory acks after 2 cycles/beat -> 4 read beats 0x100..0x10C; stall ends; ReadDataM=mem[0x100].
//  2) LW 0x104 after (1) -> hit, CacheStall=0 same cycle, no mem_req.
//  3) mem[0x200]=0x80FF7F01, line filled:
//     - LB 0x203 -> 0xFFFFFF80; LBU 0x203 -> 0x00000080.
//     - LH 0x202 -> 0xFFFF80FF; LHU 0x200 -> 0x00007F01.
//  4) SB 0x201 data 0xAB on a cached line:
//     - write beat wstrb=0010, wdata=0x0000AB00.
//     - then LW 0x200 hits with 0x80FFAB01.
//  5) SW to an uncached line -> one write beat, stall released after ack; following LW to that line misses (no allocate).
//  6) Reset (rst=0) during FILL beat 2 -> mem_req drops; stray ack ignored; re-issuing the load refills all 4 beats.
//  7) Alias: two addresses with the same set index and different tags, loaded alternately -> each load misses and refills.

Source files
------------

// File: rtl/dcache_mem_stage.sv
// Direct-mapped, write-through, no-write-allocate data cache for the M stage.
// Loads hit combinationally; misses refill a whole line over a word-wide req/ack port.
module dcache_mem_stage #(
  parameter int NUM_SETS       = 64,
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_WIDTH     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            AddressingControlM,
  input  logic                  MemReadM,
  input  logic                  MemWriteM,
  input  logic [ADDR_WIDTH-1:0] ALUResultM,
  input  logic [31:0]           WriteDataM,
  output logic [31:0]           ReadDataM,
  output logic                  CacheStall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ack
);

  localparam int WIW  = $clog2(WORDS_PER_LINE);
  localparam int SIW  = $clog2(NUM_SETS);
  localparam int LIW  = WIW + SIW;
  localparam int TAGW = ADDR_WIDTH - 2 - LIW;
  localparam logic [LIW-1:0] WMASK = LIW'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

  state_t              state_q, state_d;
  logic [NUM_SETS-1:0] valid_q;
  logic [TAGW-1:0]     tag_q  [NUM_SETS];
  logic [31:0]         data_q [NUM_SETS*WORDS_PER_LINE];
  logic [LIW-1:0]      fill_q;
  logic                store_done_q;

  logic [TAGW-1:0] tag;
  logic [SIW-1:0]  set;
  logic [LIW-1:0]  widx;
  logic [1:0]      off;
  logic            hit;
  logic            fill_last;
  logic [35:0]     lanes;

  function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [2:0] f3,
                                              input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  // Returns {strobe, lane-aligned data}.
  function automatic logic [35:0] store_lanes(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [31:0] wd);
    case (f3)
      3'b000:  return {4'b0001 << a, {24'd0, wd[7:0]} << {a, 3'b000}};
      3'b001:  return a[1] ? {4'b1100, wd[15:0], 16'd0} : {4'b0011, 16'd0, wd[15:0]};
      default: return {4'b1111, wd};
    endcase
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] old, input logic [31:0] nw,
                                             input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (strb[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  assign tag       = ALUResultM[ADDR_WIDTH-1 -: TAGW];
  assign set       = ALUResultM[2+WIW +: SIW];
  assign widx      = ALUResultM[2 +: LIW];
  assign off       = ALUResultM[1:0];
  assign hit       = valid_q[set] && (tag_q[set] == tag);
  assign fill_last = (fill_q & WMASK) == WMASK;
  assign lanes     = store_lanes(AddressingControlM, off, WriteDataM);

  assign ReadDataM = (MemReadM && !MemWriteM) ? load_extend(data_q[widx], AddressingControlM, off)
                                              : 32'd0;

  always_comb begin
    state_d    = state_q;
    CacheStall = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = 32'd0;
    mem_wstrb  = 4'd0;
    case (state_q)
      IDLE: begin
        if (MemWriteM) begin
          if (!store_done_q) begin
            CacheStall = 1'b1;
            state_d    = WRITE;
          end
        end else if (MemReadM && !hit) begin
          CacheStall = 1'b1;
          state_d    = FILL;
        end
      end
      FILL: begin
        CacheStall = 1'b1;
        mem_req    = 1'b1;
        mem_addr   = {tag, fill_q, 2'b00};
        if (mem_ack && fill_last) state_d = IDLE;
      end
      WRITE: begin
        CacheStall = 1'b1;
        mem_req    = 1'b1;
        mem_we     = 1'b1;
        mem_addr   = {ALUResultM[ADDR_WIDTH-1:2], 2'b00};
        mem_wdata  = lanes[31:0];
        mem_wstrb  = lanes[35:32];
        if (mem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // An in-flight request is abandoned the moment reset is seen.
    if (!rst) begin
      mem_req = 1'b0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      store_done_q <= 1'b0;
      fill_q       <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == WRITE && mem_ack) store_done_q <= 1'b1;
      else if (!CacheStall)            store_done_q <= 1'b0;
      // The line is invalid for the whole refill so a partial line is never hit.
      if (state_q == IDLE && state_d == FILL) begin
        valid_q[set] <= 1'b0;
        fill_q       <= widx & ~WMASK;
      end else if (state_q == FILL && mem_ack) begin
        fill_q <= fill_q + 1'b1;
        if (fill_last) valid_q[set] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == FILL && mem_ack) begin
      data_q[fill_q] <= mem_rdata;
      if (fill_last) tag_q[set] <= tag;
    end
    if (state_q == WRITE && mem_ack && hit)
      data_q[widx] <= byte_merge(data_q[widx], lanes[31:0], lanes[35:32]);
  end

endmodule

// File: tb/tb_dcache_mem_stage.sv
// Directed bench for dcache_mem_stage: table of hit vectors plus hand-written
// miss, store, reset-abort and alias sequences against a small backing-memory model.
module tb_dcache_mem_stage;

  logic        clk;
  logic        rst;
  logic [2:0]  AddressingControlM;
  logic        MemReadM, MemWriteM;
  logic [31:0] ALUResultM, WriteDataM, ReadDataM;
  logic        CacheStall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;

  dcache_mem_stage #(.NUM_SETS(64), .WORDS_PER_LINE(4), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .AddressingControlM(AddressingControlM),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .ReadDataM(ReadDataM), .CacheStall(CacheStall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] bmem [0:1023];
  logic [31:0] rd_log [0:255];
  int          rd_beats = 0;
  int          wr_beats = 0;
  logic [31:0] wr_addr, wr_data;
  logic [3:0]  wr_strb;
  int          wcnt = 0;

  // Backing memory: acks each beat two cycles after the request is seen.
  always @(negedge clk) begin
    if (mem_ack) begin
      mem_ack = 1'b0;
    end else if (mem_req) begin
      wcnt++;
      if (wcnt >= 2) begin
        wcnt    = 0;
        mem_ack = 1'b1;
        if (mem_we) begin
          wr_addr = mem_addr;
          wr_strb = mem_wstrb;
          wr_data = mem_wdata;
          wr_beats++;
          for (int b = 0; b < 4; b++)
            if (mem_wstrb[b]) bmem[mem_addr[11:2]][8*b +: 8] = mem_wdata[8*b +: 8];
        end else begin
          mem_rdata = bmem[mem_addr[11:2]];
          if (rd_beats < 256) rd_log[rd_beats] = mem_addr;
          rd_beats++;
        end
      end
    end else begin
      wcnt = 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    AddressingControlM = 3'b010;
    MemReadM   = 1'b0;
    MemWriteM  = 1'b0;
    ALUResultM = 32'd0;
    WriteDataM = 32'd0;
  endtask

  // Called at posedge+2; holds the request until the stall drops, then retires it.
  task automatic access(input logic [2:0] f3, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int cyc, output logic [31:0] rdata);
    AddressingControlM = f3;
    MemReadM   = rd;
    MemWriteM  = wr;
    ALUResultM = a;
    WriteDataM = wd;
    cyc = 0;
    #1;
    while (CacheStall && cyc < 200) begin
      @(posedge clk); #2;
      cyc++;
    end
    if (CacheStall) begin
      bad++; total++;
      $display("FAIL stall_timeout: addr %h still stalled after %0d cycles", a, cyc);
    end
    rdata = ReadDataM;
    @(posedge clk); #2;
    idle_inputs();
  endtask

  // Checks a line refill: four ascending read beats from the line base.
  task automatic chk_fill(input string nm, input int b0, input logic [31:0] base);
    chk({nm, "_beats"}, 32'(rd_beats - b0), 32'd4);
    for (int i = 0; i < 4; i++)
      chk({nm, "_addr"}, rd_log[b0 + i], base + 32'(4 * i));
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vt [13];

  int          cyc, b0, w0;
  logic [31:0] rdata;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{3'b000, 1'b1, 1'b0, 32'h203, 32'hFFFFFF80};
    vt[1]  = '{3'b100, 1'b1, 1'b0, 32'h203, 32'h00000080};
    vt[2]  = '{3'b001, 1'b1, 1'b0, 32'h202, 32'hFFFF80FF};
    vt[3]  = '{3'b101, 1'b1, 1'b0, 32'h200, 32'h00007F01};
    vt[4]  = '{3'b000, 1'b1, 1'b0, 32'h201, 32'h0000007F};
    vt[5]  = '{3'b000, 1'b1, 1'b0, 32'h200, 32'h00000001};
    vt[6]  = '{3'b101, 1'b1, 1'b0, 32'h202, 32'h000080FF};
    vt[7]  = '{3'b011, 1'b1, 1'b0, 32'h203, 32'h80FF7F01};
    vt[8]  = '{3'b010, 1'b1, 1'b0, 32'h20C, 32'h1000020C};
    vt[9]  = '{3'b010, 1'b1, 1'b0, 32'h108, 32'h10000108};
    vt[10] = '{3'b010, 1'b0, 1'b0, 32'h200, 32'h00000000};
    vt[11] = '{3'b010, 1'b1, 1'b0, 32'h202, 32'h80FF7F01};
    vt[12] = '{3'b001, 1'b1, 1'b0, 32'h203, 32'hFFFF80FF};

    for (int i = 0; i < 1024; i++) bmem[i] = 32'h1000_0000 + 32'(4 * i);
    bmem[32'h200 >> 2] = 32'h80FF7F01;
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    idle_inputs();

    // Reset
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_mem_req", {31'd0, mem_req}, 32'd0);
    chk("reset_stall", {31'd0, CacheStall}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #2;

    // Cold miss and refill of 0x100
    b0 = rd_beats;
    access(3'b010, 1'b1, 1'b0, 32'h100, 32'd0, cyc, rdata);
    chk_fill("fill100", b0, 32'h100);
    chk("lw100_data", rdata, 32'h10000100);
    chk("lw100_lat", {31'd0, cyc >= 5}, 32'd1);

    // Hit on the same line
    b0 = rd_beats;
    access(3'b010, 1'b1, 1'b0, 32'h104, 32'd0, cyc, rdata);
    chk("lw104_cycles", 32'(cyc), 32'd0);
    chk("lw104_data", rdata, 32'h10000104);
    chk("lw104_no_req", 32'(rd_beats - b0), 32'd0);

    // Fill 0x200 then hit-vector table
    b0 = rd_beats;
    access(3'b010, 1'b1, 1'b0, 32'h200, 32'd0, cyc, rdata);
    chk_fill("fill200", b0, 32'h200);
    b0 = rd_beats;
    for (int i = 0; i < 13; i++) begin
      AddressingControlM = vt[i].f3;
      MemReadM   = vt[i].rd;
      MemWriteM  = vt[i].wr;
      ALUResultM = vt[i].addr;
      #1;
      chk($sformatf("vec%0d_data", i), ReadDataM, vt[i].exp_rd);
      chk($sformatf("vec%0d_stall", i), {31'd0, CacheStall}, 32'd0);
      chk($sformatf("vec%0d_req", i), {31'd0, mem_req}, 32'd0);
      @(posedge clk); #2;
    end
    idle_inputs();
    chk("table_no_beats", 32'(rd_beats - b0), 32'd0);

    // Byte and half stores to a cached line
    w0 = wr_beats;
    b0 = rd_beats;
    access(3'b000, 1'b0, 1'b1, 32'h201, 32'h000000AB, cyc, rdata);
    chk("sb_beats", 32'(wr_beats - w0), 32'd1);
    chk("sb_strb", {28'd0, wr_strb}, 32'h2);
    chk("sb_wdata", wr_data, 32'h0000AB00);
    chk("sb_addr", wr_addr, 32'h200);
    access(3'b010, 1'b1, 1'b0, 32'h200, 32'd0, cyc, rdata);
    chk("sb_merge_hit", 32'(cyc), 32'd0);
    chk("sb_merge_data", rdata, 32'h80FFAB01);
    access(3'b001, 1'b0, 1'b1, 32'h202, 32'h00001234, cyc, rdata);
    chk("sh_strb", {28'd0, wr_strb}, 32'hC);
    chk("sh_wdata", wr_data, 32'h12340000);
    access(3'b010, 1'b1, 1'b0, 32'h200, 32'd0, cyc, rdata);
    chk("sh_merge_data", rdata, 32'h1234AB01);
    chk("stores_no_reads", 32'(rd_beats - b0), 32'd0);

    // Store to an uncached line: no allocate
    w0 = wr_beats;
    b0 = rd_beats;
    access(3'b010, 1'b0, 1'b1, 32'h303, 32'hDEADBEEF, cyc, rdata);
    chk("sw_beats", 32'(wr_beats - w0), 32'd1);
    chk("sw_strb", {28'd0, wr_strb}, 32'hF);
    chk("sw_addr", wr_addr, 32'h300);
    chk("sw_no_reads", 32'(rd_beats - b0), 32'd0);
    access(3'b010, 1'b1, 1'b0, 32'h300, 32'd0, cyc, rdata);
    chk_fill("fill300", b0, 32'h300);
    chk("lw300_data", rdata, 32'hDEADBEEF);

    // Reset during the second refill beat
    b0 = rd_beats;
    AddressingControlM = 3'b010;
    MemReadM   = 1'b1;
    ALUResultM = 32'h400;
    cyc = 0;
    while (rd_beats < b0 + 1 && cyc < 100) begin
      @(posedge clk); #2;
      cyc++;
    end
    chk("abort_first_beat", 32'(rd_beats - b0), 32'd1);
    rst = 1'b0;
    @(posedge clk); #2;
    chk("abort_req_drop", {31'd0, mem_req}, 32'd0);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk); #1;
    mem_ack = 1'b1;
    @(posedge clk); #2;
    chk("stray_ack_req", {31'd0, mem_req}, 32'd0);
    chk("stray_ack_stall", {31'd0, CacheStall}, 32'd0);
    @(posedge clk); #2;
    chk("stray_ack_no_beats", 32'(rd_beats - b0), 32'd1);
    b0 = rd_beats;
    access(3'b010, 1'b1, 1'b0, 32'h404, 32'd0, cyc, rdata);
    chk_fill("refill400", b0, 32'h400);
    chk("lw404_data", rdata, 32'h10000404);
    b0 = rd_beats;
    access(3'b010, 1'b1, 1'b0, 32'h100, 32'd0, cyc, rdata);
    chk_fill("post_reset100", b0, 32'h100);

    // Alias: 0x100 and 0x500 share set index, differ in tag
    b0 = rd_beats;
    access(3'b010, 1'b1, 1'b0, 32'h500, 32'd0, cyc, rdata);
    chk_fill("alias500a", b0, 32'h500);
    chk("alias500a_data", rdata, 32'h10000500);
    b0 = rd_beats;
    access(3'b010, 1'b1, 1'b0, 32'h100, 32'd0, cyc, rdata);
    chk_fill("alias100", b0, 32'h100);
    chk("alias100_data", rdata, 32'h10000100);
    b0 = rd_beats;
    access(3'b010, 1'b1, 1'b0, 32'h508, 32'd0, cyc, rdata);
    chk_fill("alias500b", b0, 32'h500);
    chk("alias508_data", rdata, 32'h10000508);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
